// File: rtl/resampler_cfg_ctrl_pkg.sv
// Shared types and constants for the resampler configuration sequencer.
// The round-type encodings are also consumed by the round stage.
package resampler_cfg_ctrl_pkg;

  localparam int RS_CFG_W = 16;

  localparam logic [2:0] RND_TO_ZERO = 3'b001;
  localparam logic [2:0] RND_NEAREST = 3'b010;
  localparam logic [2:0] RND_TRUNC   = 3'b100;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_APPLY,
    ST_FLUSH,
    ST_SETTLE
  } rs_ctrl_state_e;

  typedef struct packed {
    logic [RS_CFG_W-1:0] dec;
    logic [RS_CFG_W-1:0] interp;
    logic [2:0]          round;
  } rs_cfg_t;

  function automatic logic round_is_onehot(input logic [2:0] r);
    return (r == RND_TO_ZERO) || (r == RND_NEAREST) || (r == RND_TRUNC);
  endfunction

endpackage

// File: rtl/resampler_cfg_ctrl_if.sv
// Valid/ready configuration port carrying new decimation, interpolation
// and round-type settings.
interface resampler_cfg_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [DATA_WIDTH-1:0] cfg_dec;
  logic [DATA_WIDTH-1:0] cfg_int;
  logic [2:0]            cfg_round;

  modport master (
    output cfg_valid, cfg_dec, cfg_int, cfg_round,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_dec, cfg_int, cfg_round,
    output cfg_ready
  );
endinterface

// File: rtl/resampler_cfg_ctrl_quiet_detect.sv
// Counts consecutive cycles without resampler output activity; done_o fires
// on the QUIET_CYCLES-th quiet cycle since the last start or activity.
module resampler_cfg_ctrl_quiet_detect #(
  parameter int QUIET_CYCLES = 24
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic en_i,
  input  logic activity_i,
  output logic done_o
);
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

  logic [QW-1:0] cnt_reg;

  assign done_o = en_i && !activity_i && (cnt_reg == QUIET_LAST);

  // The terminal count always forces a state exit, so no saturation is needed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else if (start_i || activity_i || done_o) begin
      cnt_reg <= '0;
    end else if (en_i) begin
      cnt_reg <= cnt_reg + QW'(1);
    end
  end
endmodule

// File: rtl/resampler_cfg_ctrl.sv
// Run-time configuration sequencer: gates the input stream, drains the
// resampler, commits new ratios, flushes the FIR with zero beats, then resumes.
module resampler_cfg_ctrl
  import resampler_cfg_ctrl_pkg::*;
#(
  parameter int         DATA_WIDTH   = 16,
  parameter int         TAP_NUM      = 16,
  parameter int         QUIET_CYCLES = 24,
  parameter int         MAX_RATIO    = 8,
  parameter int         DEF_DEC      = 1,
  parameter int         DEF_INT      = 1,
  parameter logic [2:0] DEF_ROUND    = 3'b010
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  resampler_cfg_ctrl_if.slave     cfg,
  input  logic                    s_tvalid_i,
  output logic                    s_tready_o,
  output logic                    m_tvalid_o,
  input  logic                    m_tready_i,
  output logic                    zero_data_o,
  input  logic                    rs_tvalid_i,
  output logic                    out_mask_o,
  output logic                    en_o,
  output logic [DATA_WIDTH-1:0]   decimation_o,
  output logic [DATA_WIDTH-1:0]   interpolation_o,
  output logic [2:0]              round_type_o,
  output logic                    busy_o,
  output logic                    err_o
);
  localparam int FW = $clog2(TAP_NUM + 1);
  localparam logic [FW-1:0]         FLUSH_LAST = FW'(TAP_NUM - 1);
  localparam logic [DATA_WIDTH-1:0] RATIO_MAX  = DATA_WIDTH'(MAX_RATIO);
  localparam rs_cfg_t CFG_DEFAULT = '{
    dec:    RS_CFG_W'(DEF_DEC),
    interp: RS_CFG_W'(DEF_INT),
    round:  DEF_ROUND
  };

  rs_ctrl_state_e state_reg;
  rs_cfg_t        shadow_reg;
  rs_cfg_t        commit_reg;
  rs_cfg_t        cfg_in;
  logic [FW-1:0]  flush_cnt_reg;
  logic           run_reg;
  logic           zero_reg;
  logic           en_reg;
  logic           mask_reg;
  logic           busy_reg;
  logic           err_reg;
  logic           cfg_hs;
  logic           cfg_legal;
  logic           flush_last;
  logic           quiet_en;
  logic           quiet_start;
  logic           quiet_done;

  assign cfg_in = '{
    dec:    RS_CFG_W'(cfg.cfg_dec),
    interp: RS_CFG_W'(cfg.cfg_int),
    round:  cfg.cfg_round
  };

  assign cfg_legal = (cfg.cfg_dec != '0) && (cfg.cfg_dec <= RATIO_MAX) &&
                     (cfg.cfg_int != '0) && (cfg.cfg_int <= RATIO_MAX) &&
                     round_is_onehot(cfg.cfg_round);

  assign cfg_hs      = cfg.cfg_valid && (state_reg == ST_RUN);
  assign flush_last  = (state_reg == ST_FLUSH) && m_tready_i && (flush_cnt_reg == FLUSH_LAST);
  assign quiet_en    = (state_reg == ST_DRAIN) || (state_reg == ST_SETTLE);
  assign quiet_start = (cfg_hs && cfg_legal) || flush_last;

  resampler_cfg_ctrl_quiet_detect #(
    .QUIET_CYCLES (QUIET_CYCLES)
  ) u_quiet (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (quiet_start),
    .en_i       (quiet_en),
    .activity_i (rs_tvalid_i),
    .done_o     (quiet_done)
  );

  // Outside RUN the upstream is stalled and only flush beats reach the resampler.
  assign cfg.cfg_ready   = run_reg;
  assign s_tready_o      = run_reg && m_tready_i;
  assign m_tvalid_o      = run_reg ? s_tvalid_i : zero_reg;
  assign zero_data_o     = zero_reg;
  assign en_o            = en_reg;
  assign out_mask_o      = mask_reg;
  assign busy_o          = busy_reg;
  assign err_o           = err_reg;
  assign decimation_o    = DATA_WIDTH'(commit_reg.dec);
  assign interpolation_o = DATA_WIDTH'(commit_reg.interp);
  assign round_type_o    = commit_reg.round;

  // Output flags are loaded together with the state they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= ST_RUN;
      shadow_reg    <= CFG_DEFAULT;
      commit_reg    <= CFG_DEFAULT;
      flush_cnt_reg <= '0;
      run_reg       <= 1'b1;
      zero_reg      <= 1'b0;
      en_reg        <= 1'b1;
      mask_reg      <= 1'b1;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      unique case (state_reg)
        ST_RUN: begin
          if (cfg_hs) begin
            if (cfg_legal) begin
              shadow_reg <= cfg_in;
              state_reg  <= ST_DRAIN;
              run_reg    <= 1'b0;
              busy_reg   <= 1'b1;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (quiet_done) begin
            state_reg <= ST_APPLY;
            en_reg    <= 1'b0;
            mask_reg  <= 1'b0;
          end
        end
        ST_APPLY: begin
          commit_reg    <= shadow_reg;
          flush_cnt_reg <= '0;
          state_reg     <= ST_FLUSH;
          en_reg        <= 1'b1;
          zero_reg      <= 1'b1;
        end
        ST_FLUSH: begin
          if (flush_last) begin
            state_reg     <= ST_SETTLE;
            zero_reg      <= 1'b0;
            flush_cnt_reg <= '0;
          end else if (m_tready_i) begin
            flush_cnt_reg <= flush_cnt_reg + FW'(1);
          end
        end
        ST_SETTLE: begin
          if (quiet_done) begin
            state_reg <= ST_RUN;
            run_reg   <= 1'b1;
            mask_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_RUN;
          run_reg   <= 1'b1;
          zero_reg  <= 1'b0;
          en_reg    <= 1'b1;
          mask_reg  <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end
endmodule
